// File: rtl/ysyx_040750_cache_refill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ysyx_040750_cache_refill_pkg                                      |
// | Brief  : FSM state encoding and AXI burst constants for the refill engine. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package ysyx_040750_cache_refill_pkg;

   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_RD   = 2'd2,
      ST_FILL = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_040750_cache_refill_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ysyx_040750_cache_refill_if                                       |
// | Brief  : AXI read address/data channel between refill engine and crossbar. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface ysyx_040750_cache_refill_if;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [63:0] rdata;
   logic        rvalid;
   logic        rlast;
   logic        rready;

   modport master (
      output araddr, arvalid, arlen, arsize, arburst, rready,
      input  arready, rdata, rvalid, rlast
   );

   modport slave (
      input  araddr, arvalid, arlen, arsize, arburst, rready,
      output arready, rdata, rvalid, rlast
   );

endinterface
`default_nettype wire

// File: rtl/ysyx_040750_cache_refill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ysyx_040750_cache_refill                                          |
// | Brief  : Line-miss refill engine: one INCR burst per miss, critical word   |
// |          forwarded early, full line presented for the data-array write.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ysyx_040750_cache_refill
   import ysyx_040750_cache_refill_pkg::*;
#(
   parameter int LINE_BEATS = 8,
   parameter int OFF_W      = $clog2(LINE_BEATS)
) (
   input  wire                          I_clk,
   input  wire                          I_rst,
   input  wire                          I_miss_valid,
   input  wire  [31:0]                  I_miss_addr,
   output logic                         O_miss_ready,
   output logic                         O_crit_valid,
   output logic [63:0]                  O_crit_data,
   output logic                         O_fill_valid,
   output logic [31:0]                  O_fill_addr,
   output logic [64*LINE_BEATS-1:0]     O_fill_data,
   output logic                         O_fill_err,
   input  wire                          I_fill_ready,
   ysyx_040750_cache_refill_if.master   axi
);

   // Beat counter is one bit wider so it can saturate past the last slot.
   localparam logic [OFF_W:0] c_last     = (OFF_W+1)'(LINE_BEATS - 1);
   localparam logic [OFF_W:0] c_full     = (OFF_W+1)'(LINE_BEATS);
   localparam logic [OFF_W:0] c_one      = (OFF_W+1)'(1);
   localparam logic [31:0]    c_off_mask = 32'(LINE_BEATS*8 - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_line_addr;
   logic [OFF_W-1:0] r_crit_idx;
   logic [OFF_W:0]   r_beat_cnt;
   logic             r_err;
   logic             r_crit_valid;
   logic [63:0]      r_crit_data;
   logic [63:0]      r_buf [LINE_BEATS];
   logic             w_miss_hs;
   logic             w_beat_hs;

   assign w_miss_hs = (r_state == ST_IDLE) && I_miss_valid;
   assign w_beat_hs = (r_state == ST_RD) && axi.rvalid;

   always_ff @(posedge I_clk) begin
      if (I_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      O_miss_ready = 1'b0;
      axi.arvalid  = 1'b0;
      axi.rready   = 1'b0;
      O_fill_valid = 1'b0;
      O_fill_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            O_miss_ready = 1'b1;
            if (I_miss_valid) w_state_nxt = ST_AR;
         end
         ST_AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) w_state_nxt = ST_RD;
         end
         ST_RD: begin
            axi.rready = 1'b1;
            if (axi.rvalid && axi.rlast) w_state_nxt = ST_FILL;
         end
         ST_FILL: begin
            O_fill_valid = 1'b1;
            O_fill_err   = r_err;
            if (I_fill_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_line_addr  <= '0;
         r_crit_idx   <= '0;
         r_beat_cnt   <= '0;
         r_err        <= 1'b0;
         r_crit_valid <= 1'b0;
         r_crit_data  <= '0;
      end else begin
         r_crit_valid <= 1'b0;
         if (w_miss_hs) begin
            r_line_addr <= I_miss_addr & ~c_off_mask;
            r_crit_idx  <= I_miss_addr[OFF_W+2:3];
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
         end
         if (w_beat_hs) begin
            if (r_beat_cnt != c_full) r_beat_cnt <= r_beat_cnt + c_one;
            // Counter only passes crit_idx once, so the pulse is once per miss.
            if (r_beat_cnt == {1'b0, r_crit_idx}) begin
               r_crit_data  <= axi.rdata;
               r_crit_valid <= 1'b1;
            end
            if (axi.rlast)                r_err <= (r_beat_cnt != c_last);
            else if (r_beat_cnt >= c_last) r_err <= 1'b1;
         end
      end
   end

   // Line storage needs no reset; entries a short burst misses stay stale.
   always_ff @(posedge I_clk) begin
      if (!I_rst && w_beat_hs && (r_beat_cnt < c_full))
         r_buf[r_beat_cnt[OFF_W-1:0]] <= axi.rdata;
   end

   generate
      for (genvar k = 0; k < LINE_BEATS; k++) begin : g_flat
         assign O_fill_data[64*k +: 64] = r_buf[k];
      end
   endgenerate

   assign O_crit_valid = r_crit_valid;
   assign O_crit_data  = r_crit_data;
   assign O_fill_addr  = r_line_addr;
   assign axi.araddr   = r_line_addr;
   assign axi.arlen    = 8'(LINE_BEATS - 1);
   assign axi.arsize   = AXI_SIZE_8B;
   assign axi.arburst  = AXI_BURST_INCR;

endmodule
`default_nettype wire
